// File: rtl/ex_muldiv_pkg.sv
// Shared constants for the RV32M multiply/divide engine: funct3/funct7 codes and FSM encodings.
package ex_muldiv_pkg;

    localparam logic [2:0] INST_MUL    = 3'b000;
    localparam logic [2:0] INST_MULH   = 3'b001;
    localparam logic [2:0] INST_MULHSU = 3'b010;
    localparam logic [2:0] INST_MULHU  = 3'b011;
    localparam logic [2:0] INST_DIV    = 3'b100;
    localparam logic [2:0] INST_DIVU   = 3'b101;
    localparam logic [2:0] INST_REM    = 3'b110;
    localparam logic [2:0] INST_REMU   = 3'b111;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    localparam logic [1:0] STATE_IDLE = 2'd0;
    localparam logic [1:0] STATE_CALC = 2'd1;
    localparam logic [1:0] STATE_DONE = 2'd2;

    // funct3[2] clear selects the multiply group.
    function automatic logic is_mul(input logic [2:0] op);
        return !op[2];
    endfunction

endpackage

// File: rtl/ex_div_step.sv
// One combinational restoring-division step: trial-subtract the divisor from the shifted partial remainder.
module ex_div_step
    import ex_muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN:0]   rem_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] rem_o,
    output logic            q_o
);

    logic [XLEN:0] diff;

    // NOTE: every output of a combinational block is assigned on every path, so no latch is inferred.
    always_comb begin
        diff  = rem_i - {1'b0, divisor_i};
        q_o   = (rem_i >= {1'b0, divisor_i});
        rem_o = q_o ? diff[XLEN-1:0] : rem_i[XLEN-1:0];
    end

endmodule

// File: rtl/ex_muldiv.sv
// Multi-cycle RV32M multiply/divide engine (shift-add multiply, restoring divide, one bit per cycle).
// Define EX_MULDIV_FAST_MUL_EN for a single-cycle combinational multiply path (IDLE -> DONE).
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] op1_i,
    input  logic [XLEN-1:0] op2_i,
    input  logic [4:0]      rd_addr_i,
    input  logic            flush_i,
    output logic            hold_flag_o,
    output logic            busy_o,
    output logic [4:0]      rd_addr_o,
    output logic [XLEN-1:0] rd_data_o,
    output logic            rd_wen_o
);

    localparam int CNT_W = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [2:0]        op_q;
    logic [4:0]        rd_q;
    logic [2*XLEN-1:0] prod_q;
    logic [XLEN-1:0]   opb_q;
    logic              neg_q;
    logic              div_zero_q;
    logic              ovf_q;

    logic              launch;
    logic              a_neg, b_neg, res_neg, div_zero, ovf;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [2*XLEN-1:0] init_prod;
    logic [XLEN-1:0]   init_opb;

    assign launch = start_i && !flush_i && (state_q == STATE_IDLE);

    // Magnitudes and result sign decided at launch; REM takes the dividend's sign.
    always_comb begin
        a_neg    = op1_i[XLEN-1] && (op_i == INST_MULH || op_i == INST_MULHSU ||
                                     op_i == INST_DIV  || op_i == INST_REM);
        b_neg    = op2_i[XLEN-1] && (op_i == INST_MULH || op_i == INST_DIV || op_i == INST_REM);
        a_mag    = a_neg ? -op1_i : op1_i;
        b_mag    = b_neg ? -op2_i : op2_i;
        res_neg  = (op_i == INST_REM) ? a_neg : (a_neg ^ b_neg);
        div_zero = (op2_i == '0);
        ovf      = (op_i == INST_DIV || op_i == INST_REM) && (op1_i == MOST_NEG) && (op2_i == '1);
        if (is_mul(op_i)) begin
            init_prod = {{XLEN{1'b0}}, b_mag};
            init_opb  = a_mag;
        end else begin
            init_prod = {{XLEN{1'b0}}, a_mag};
            init_opb  = b_mag;
        end
    end

`ifdef EX_MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod;
    assign fast_prod = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
`endif

    // Multiply: {acc_hi, multiplier} shifts right, adding the multiplicand when the LSB is set.
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN-1:0]   step_rem;
    logic              step_q;
    logic [2*XLEN-1:0] div_next;

    always_comb begin
        mul_sum  = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, opb_q} : '0);
        mul_next = {mul_sum, prod_q[XLEN-1:1]};
        div_next = {step_rem, prod_q[XLEN-2:0], step_q};
    end

    // Divide: {remainder, dividend/quotient} shifts left one bit per step.
    ex_div_step #(.XLEN(XLEN)) u_div_step (
        .rem_i     (prod_q[2*XLEN-1:XLEN-1]),
        .divisor_i (opb_q),
        .rem_o     (step_rem),
        .q_o       (step_q)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    // NOTE: every register here is a flop with async reset; there is no memory array to leave unreset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= STATE_IDLE;
            cnt_q      <= '0;
            op_q       <= '0;
            rd_q       <= '0;
            prod_q     <= '0;
            opb_q      <= '0;
            neg_q      <= 1'b0;
            div_zero_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            case (state_q)
                STATE_IDLE: begin
                    cnt_q <= '0;
                    if (launch) begin
                        op_q       <= op_i;
                        rd_q       <= rd_addr_i;
                        opb_q      <= init_opb;
                        neg_q      <= res_neg;
                        div_zero_q <= div_zero;
                        ovf_q      <= ovf;
`ifdef EX_MULDIV_FAST_MUL_EN
                        if (is_mul(op_i)) begin
                            state_q <= STATE_DONE;
                            prod_q  <= fast_prod;
                        end else begin
                            state_q <= STATE_CALC;
                            prod_q  <= init_prod;
                        end
`else
                        state_q <= STATE_CALC;
                        prod_q  <= init_prod;
`endif
                    end
                end
                STATE_CALC: begin
                    if (flush_i) begin
                        state_q <= STATE_IDLE;
                        cnt_q   <= '0;
                    end else begin
                        prod_q <= is_mul(op_q) ? mul_next : div_next;
                        cnt_q  <= cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(XLEN - 1)) begin
                            state_q <= STATE_DONE;
                        end
                    end
                end
                default: begin
                    state_q <= STATE_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quo_s, rem_s, result;

    // Divide-by-zero REM needs no override: the magnitude path leaves |op1| with op1's sign.
    always_comb begin
        prod_s = neg_q ? -prod_q : prod_q;
        quo_s  = neg_q ? -prod_q[XLEN-1:0] : prod_q[XLEN-1:0];
        rem_s  = neg_q ? -prod_q[2*XLEN-1:XLEN] : prod_q[2*XLEN-1:XLEN];
        result = '0;
        case (op_q)
            INST_MUL:                              result = prod_s[XLEN-1:0];
            INST_MULH, INST_MULHSU, INST_MULHU:    result = prod_s[2*XLEN-1:XLEN];
            INST_DIV, INST_DIVU:
                result = div_zero_q ? '1 : (ovf_q ? MOST_NEG : quo_s);
            default:
                result = ovf_q ? '0 : rem_s;
        endcase
    end

    logic done;
    assign done        = (state_q == STATE_DONE) && !flush_i;
    assign hold_flag_o = launch || (state_q == STATE_CALC);
    assign busy_o      = (state_q != STATE_IDLE);
    assign rd_wen_o    = done;
    assign rd_addr_o   = done ? rd_q : '0;
    assign rd_data_o   = done ? result : '0;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed self-checking bench for ex_muldiv; expected results are hand-computed constants.
module tb_ex_muldiv;
    import ex_muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_i;
    logic [2:0]  op_i;
    logic [31:0] op1_i, op2_i;
    logic [4:0]  rd_addr_i;
    logic        flush_i;
    logic        hold_flag_o, busy_o, rd_wen_o;
    logic [4:0]  rd_addr_o;
    logic [31:0] rd_data_o;

    int errors = 0;
    int checks = 0;

`ifdef EX_MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    ex_muldiv #(.XLEN(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .op_i        (op_i),
        .op1_i       (op1_i),
        .op2_i       (op2_i),
        .rd_addr_i   (rd_addr_i),
        .flush_i     (flush_i),
        .hold_flag_o (hold_flag_o),
        .busy_o      (busy_o),
        .rd_addr_o   (rd_addr_o),
        .rd_data_o   (rd_data_o),
        .rd_wen_o    (rd_wen_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Launch at a negedge, then sample each following negedge until the write-back strobe.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] exp_data, input int exp_lat);
        int n = 0;
        int holds = 0;
        bit got = 1'b0;
        @(negedge clk);
        op_i = op; op1_i = a; op2_i = b; rd_addr_i = rd; start_i = 1'b1;
        #1;
        while (!got && n <= 200) begin
            if (hold_flag_o) holds++;
            if (rd_wen_o) begin
                got = 1'b1;
                check({tag, " latency"}, n, exp_lat);
                check({tag, " rd_addr"}, {27'd0, rd_addr_o}, {27'd0, rd});
                check({tag, " rd_data"}, rd_data_o, exp_data);
                check({tag, " busy_done"}, {31'd0, busy_o}, 32'd1);
            end else begin
                @(negedge clk);
                start_i = 1'b0;
                n++;
                #1;
            end
        end
        check({tag, " completed"}, {31'd0, got}, 32'd1);
        check({tag, " hold_cycles"}, holds, exp_lat);
        @(negedge clk);
        #1;
        check({tag, " wen_after"}, {31'd0, rd_wen_o}, 32'd0);
        check({tag, " idle_after"}, {31'd0, busy_o}, 32'd0);
    endtask

    initial begin
        int wen_seen;
        rst_n = 1'b0; start_i = 1'b0; op_i = '0; op1_i = '0; op2_i = '0;
        rd_addr_i = '0; flush_i = 1'b0;
        repeat (3) @(negedge clk);
        check("reset hold", {31'd0, hold_flag_o}, 32'd0);
        check("reset busy", {31'd0, busy_o}, 32'd0);
        check("reset wen", {31'd0, rd_wen_o}, 32'd0);
        check("reset rd_addr", {27'd0, rd_addr_o}, 32'd0);
        check("reset rd_data", rd_data_o, 32'd0);
        rst_n = 1'b1;

        run_op("mul", INST_MUL, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, MUL_LAT);
        run_op("mulh", INST_MULH, 32'h8000_0000, 32'h8000_0000, 5'd6, 32'h4000_0000, MUL_LAT);
        run_op("mulhu", INST_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'hFFFF_FFFE, MUL_LAT);
        run_op("mulhsu", INST_MULHSU, 32'hFFFF_FFFF, 32'd2, 5'd8, 32'hFFFF_FFFF, MUL_LAT);
        run_op("div", INST_DIV, 32'hFFFF_FFF9, 32'd2, 5'd9, 32'hFFFF_FFFD, DIV_LAT);
        run_op("rem", INST_REM, 32'hFFFF_FFF9, 32'd2, 5'd10, 32'hFFFF_FFFF, DIV_LAT);
        run_op("divu", INST_DIVU, 32'd100, 32'd7, 5'd11, 32'd14, DIV_LAT);
        run_op("remu", INST_REMU, 32'd100, 32'd7, 5'd12, 32'd2, DIV_LAT);
        run_op("div0", INST_DIV, 32'd5, 32'd0, 5'd13, 32'hFFFF_FFFF, DIV_LAT);
        run_op("rem0", INST_REM, 32'd5, 32'd0, 5'd14, 32'd5, DIV_LAT);
        run_op("div_ovf", INST_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000, DIV_LAT);
        run_op("rem_ovf", INST_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'd0, DIV_LAT);
        run_op("mul_x0", INST_MUL, 32'd6, 32'd7, 5'd0, 32'd42, MUL_LAT);

        // Flush and start in the same idle cycle: no launch.
        @(negedge clk);
        op_i = INST_DIVU; op1_i = 32'd9; op2_i = 32'd3; start_i = 1'b1; flush_i = 1'b1;
        #1;
        check("flush_start hold", {31'd0, hold_flag_o}, 32'd0);
        @(negedge clk);
        start_i = 1'b0; flush_i = 1'b0;
        #1;
        check("flush_start busy", {31'd0, busy_o}, 32'd0);

        // Flush at CALC cycle 10.
        wen_seen = 0;
        @(negedge clk);
        op_i = INST_DIVU; op1_i = 32'd100; op2_i = 32'd7; rd_addr_i = 5'd3; start_i = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            start_i = 1'b0;
            #1;
            if (rd_wen_o) wen_seen++;
        end
        check("flush busy_before", {31'd0, busy_o}, 32'd1);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        #1;
        if (rd_wen_o) wen_seen++;
        check("flush busy_after", {31'd0, busy_o}, 32'd0);
        check("flush hold_after", {31'd0, hold_flag_o}, 32'd0);
        check("flush no_wen", wen_seen, 32'd0);
        run_op("after_flush", INST_REMU, 32'd100, 32'd7, 5'd4, 32'd2, DIV_LAT);

        // Asynchronous reset at CALC cycle 5 of a divide.
        @(negedge clk);
        op_i = INST_DIV; op1_i = 32'd50; op2_i = 32'd5; rd_addr_i = 5'd2; start_i = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            start_i = 1'b0;
        end
        #1;
        check("rst_mid busy_before", {31'd0, busy_o}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid hold", {31'd0, hold_flag_o}, 32'd0);
        check("rst_mid busy", {31'd0, busy_o}, 32'd0);
        check("rst_mid wen", {31'd0, rd_wen_o}, 32'd0);
        check("rst_mid rd_data", rd_data_o, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("after_rst", INST_DIV, 32'd50, 32'd5, 5'd2, 32'd10, DIV_LAT);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
